// File: rtl/clk_div_if.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_if
//  Purpose  : Control/output bundle of the integer clock divider.
//             master = controller side, slave = divider side.
//  Revision : 1.0  initial release
// ============================================================================
interface clk_div_if #(
  parameter int DIV_RATIO_WIDTH = 4
);
  logic                       i_clk_en;
  logic [DIV_RATIO_WIDTH-1:0] i_div_ratio;
  logic                       o_div_clk;

  modport master (
    output i_clk_en,
    output i_div_ratio,
    input  o_div_clk
  );

  modport slave (
    input  i_clk_en,
    input  i_div_ratio,
    output o_div_clk
  );
endinterface
`default_nettype wire

// File: rtl/clk_div.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div
//  Purpose  : Runtime-programmable integer clock divider. Ratios 0/1 or a
//             disabled block pass the reference clock straight through; even
//             ratios give 50% duty, odd ratios a low phase one cycle longer.
//  Revision : 1.0  initial release
// ============================================================================
module clk_div #(
  parameter int DIV_RATIO_WIDTH = 4
) (
  input  wire logic  i_ref_clk,
  input  wire logic  i_rst,
  clk_div_if.slave   bus
);

  localparam int c_W  = DIV_RATIO_WIDTH;
  localparam int c_CW = DIV_RATIO_WIDTH - 1;

  // The longest phase is 2^(W-1) cycles, so a W-1 bit counter reaching
  // phase_len-1 is always wide enough.
  logic [c_CW-1:0] r_cnt;
  logic            r_div_q;

  logic [c_W-1:0]  w_ratio;
  logic            w_active;
  logic [c_W-1:0]  w_half;
  logic [c_W-1:0]  w_low_len;
  logic [c_W-1:0]  w_high_len;
  logic [c_W-1:0]  w_phase_len;
  logic [c_W-1:0]  w_cnt_ext;
  logic            w_phase_end;

  assign w_ratio  = bus.i_div_ratio;
  assign w_active = bus.i_clk_en && (w_ratio >= c_W'(2));

  // Low phase = ceil(N/2), high phase = floor(N/2).
  assign w_half      = w_ratio >> 1;
  assign w_low_len   = w_half + c_W'(w_ratio[0]);
  assign w_high_len  = w_half;
  assign w_phase_len = r_div_q ? w_high_len : w_low_len;

  // ">=" rather than "==" so a ratio shrunk mid-phase ends that phase on the
  // next edge instead of wrapping the counter.
  assign w_cnt_ext   = {1'b0, r_cnt};
  assign w_phase_end = (w_cnt_ext >= (w_phase_len - c_W'(1)));

  // Phase counter and divided-clock register; cleared whenever not dividing.
  always_ff @(posedge i_ref_clk) begin
    if (i_rst || !w_active) begin
      r_cnt   <= '0;
      r_div_q <= 1'b0;
    end else if (w_phase_end) begin
      r_cnt   <= '0;
      r_div_q <= ~r_div_q;
    end else begin
      r_cnt   <= r_cnt + c_CW'(1);
    end
  end

  // Pass-through switching is intentionally not glitch-free.
  assign bus.o_div_clk = w_active ? r_div_q : i_ref_clk;

endmodule
`default_nettype wire

// File: tb/tb_clk_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div
//  Purpose  : Self-checking bench for clk_div (10 ns reference clock).
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_div;

  logic clk;
  logic rst;

  clk_div_if #(.DIV_RATIO_WIDTH(4)) u_bus ();

  clk_div #(.DIV_RATIO_WIDTH(4)) u_dut (
    .i_ref_clk (clk),
    .i_rst     (rst),
    .bus       (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic act;
    logic q;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_q   = 0;
  int m_cnt = 0;

  // waveform statistics over a measurement window
  int hi_cnt, max_hi, max_lo, cur_val, cur_run, last_obs;
  bit skip_first;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_window();
    hi_cnt     = 0;
    max_hi     = 0;
    max_lo     = 0;
    cur_val    = -1;
    cur_run    = 0;
    skip_first = 1'b1;
  endtask

  // One reference cycle: model the edge, push the expectation, then compare
  // the output just after the rising edge (ref high) and after the falling
  // edge (ref low).
  task automatic cycle(input string tag);
    exp_t e;
    exp_t g;
    int   len;
    int   n;
    int   obs;
    logic act;
    @(posedge clk);
    n   = int'(u_bus.i_div_ratio);
    act = u_bus.i_clk_en && (n >= 2);
    if (rst || !act) begin
      m_q   = 0;
      m_cnt = 0;
    end else begin
      len = (m_q != 0) ? (n / 2) : ((n + 1) / 2);
      if (m_cnt >= len - 1) begin
        m_q   = 1 - m_q;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    e.act = act;
    e.q   = (m_q != 0);
    sb.push_back(e);
    #1;
    g   = sb.pop_front();
    obs = int'(u_bus.o_div_clk);
    chk({tag, "_hi"}, obs, g.act ? int'(g.q) : 1);
    last_obs = obs;
    hi_cnt  += obs;
    if (obs == cur_val) begin
      cur_run++;
    end else begin
      if (!skip_first) begin
        if (cur_val == 1 && cur_run > max_hi) max_hi = cur_run;
        if (cur_val == 0 && cur_run > max_lo) max_lo = cur_run;
      end
      if (cur_val != -1) skip_first = 1'b0;
      cur_val = obs;
      cur_run = 1;
    end
    @(negedge clk);
    #1;
    chk({tag, "_lo"}, int'(u_bus.o_div_clk), g.act ? int'(g.q) : 0);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Cycles until the output is sampled high; -1 if the bound expires.
  task automatic wait_rise(input string tag, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      cycle(tag);
      if (last_obs == 1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_low(input string tag, input int maxc);
    int ok;
    ok = 0;
    for (int i = 1; i <= maxc; i++) begin
      cycle(tag);
      if (last_obs == 0) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_reached_low"}, ok, 1);
  endtask

  task automatic measure(input string tag, input int ncyc,
                         input int exp_hi, input int exp_maxhi, input int exp_maxlo);
    start_window();
    run(tag, ncyc);
    chk({tag, "_high_count"}, hi_cnt, exp_hi);
    chk({tag, "_high_len"},   max_hi, exp_maxhi);
    chk({tag, "_low_len"},    max_lo, exp_maxlo);
  endtask

  initial begin
    int n;
    rst                = 1'b1;
    u_bus.i_clk_en     = 1'b0;
    u_bus.i_div_ratio  = 4'd0;
    start_window();

    // reset, then pass-through
    run("reset", 2);
    chk("reset_divq", int'(u_dut.r_div_q), 0);
    rst = 1'b0;
    run("passthru_init", 5);
    chk("passthru_divq", int'(u_dut.r_div_q), 0);

    // N=2
    u_bus.i_clk_en    = 1'b1;
    u_bus.i_div_ratio = 4'd2;
    wait_rise("n2_rise", 10, n);
    chk("n2_first_rise", n, 1);
    measure("n2", 10, 5, 1, 1);

    // N=4
    u_bus.i_div_ratio = 4'd4;
    run("n4_settle", 8);
    measure("n4", 32, 16, 2, 2);

    // N=3 then N=5
    u_bus.i_div_ratio = 4'd3;
    run("n3_settle", 6);
    measure("n3", 24, 8, 1, 2);
    u_bus.i_div_ratio = 4'd5;
    run("n5_settle", 10);
    measure("n5", 40, 16, 2, 3);

    // pass-through cases
    u_bus.i_div_ratio = 4'd1;
    run("ratio1", 3);
    chk("ratio1_divq", int'(u_dut.r_div_q), 0);
    u_bus.i_div_ratio = 4'd0;
    run("ratio0", 3);
    u_bus.i_clk_en    = 1'b0;
    u_bus.i_div_ratio = 4'd4;
    run("disabled", 3);
    chk("disabled_divq", int'(u_dut.r_div_q), 0);

    // re-enable N=4: fresh 2-cycle low phase
    u_bus.i_clk_en = 1'b1;
    wait_rise("reen_rise", 10, n);
    chk("reen_first_rise", n, 2);

    // reset in the middle of a high phase at N=5
    u_bus.i_div_ratio = 4'd5;
    wait_low("n5_pre", 10);
    wait_rise("n5_pre_rise", 10, n);
    chk("n5_pre_rise_found", (n > 0) ? 1 : 0, 1);
    rst = 1'b1;
    cycle("rst_mid");
    chk("rst_mid_divq", int'(u_dut.r_div_q), 0);
    rst = 1'b0;
    wait_rise("post_rst", 10, n);
    chk("post_rst_rise", n, 3);
    run("tail", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
